// File: rtl/input_debounce_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : input_debounce_ctrl
// Description : Synchronises and debounces NUM_CH asynchronous inputs (buttons,
//               IR and HDMI status lines) in the clk27 domain. Each channel has
//               its own pin polarity and produces a debounced level plus
//               press / release / long-press / auto-repeat pulses. An
//               aggregate activity pulse feeds the LCD backlight timeout.
// Ports       : clk27       - system clock
//               reset_n     - asynchronous active-low reset
//               din         - raw asynchronous pin inputs
//               level_o     - debounced level per channel, 1 = active
//               press_o     - 1-cycle pulse on accepted inactive->active
//               release_o   - 1-cycle pulse on accepted active->inactive
//               long_o      - 1-cycle pulse on long press and on each repeat
//               any_event_o - OR of all press/release/long bits, same cycle
// Revision    : 1.0 - initial release
// ============================================================================
module input_debounce_ctrl #(
  parameter int                NUM_CH       = 4,
  parameter logic [NUM_CH-1:0] INV_MASK     = 4'b0011,
  parameter int                TICK_DIV     = 27000,
  parameter int                DEB_TICKS    = 20,
  parameter int                LONG_TICKS   = 1000,
  parameter int                REPEAT_TICKS = 200
) (
  input  logic              clk27,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] din,
  output logic [NUM_CH-1:0] level_o,
  output logic [NUM_CH-1:0] press_o,
  output logic [NUM_CH-1:0] release_o,
  output logic [NUM_CH-1:0] long_o,
  output logic              any_event_o
);

  // --------------------------------------------------------------------------
  // Derived widths and constants
  // --------------------------------------------------------------------------
  localparam int c_pw       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int c_dw       = $clog2(DEB_TICKS + 1);
  localparam int c_hold_max = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int c_hw       = (c_hold_max > 0) ? $clog2(c_hold_max + 1) : 1;

  localparam logic [c_pw-1:0] c_tick_last = c_pw'(TICK_DIV - 1);
  localparam logic [c_dw-1:0] c_deb_lim   = c_dw'(DEB_TICKS);
  localparam logic [c_hw-1:0] c_long_lim  = c_hw'(LONG_TICKS);
  localparam logic [c_hw-1:0] c_rep_lim   = c_hw'(REPEAT_TICKS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } hold_st_e;

  // --------------------------------------------------------------------------
  // Two-flop synchroniser and shared tick prescaler
  // --------------------------------------------------------------------------
  logic [NUM_CH-1:0] sync1_q;
  logic [NUM_CH-1:0] sync2_q;
  logic [c_pw-1:0]   presc_q;
  logic              tick;
  logic [NUM_CH-1:0] act;

  assign tick = (presc_q == c_tick_last);
  // Polarity is removed after synchronisation so every downstream stage
  // works with "1 = active" regardless of pin wiring.
  assign act  = sync2_q ^ INV_MASK;

  always_ff @(posedge clk27 or negedge reset_n) begin
    if (!reset_n) begin
      // Loading INV_MASK makes every channel look inactive out of reset.
      sync1_q <= INV_MASK;
      sync2_q <= INV_MASK;
      presc_q <= '0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      presc_q <= tick ? '0 : presc_q + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Per-channel debounce and hold state machine
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [c_dw-1:0] deb_q;
    logic [c_hw-1:0] hold_q;
    hold_st_e        st_q;
    logic            frozen_q;
    logic            level_q;
    logic            press_q;
    logic            release_q;
    logic            long_q;
    logic            deb_done;
    logic            rise;
    logic            fall;

    // The tick that brings the counter to its limit accepts the new level.
    assign deb_done = tick && (act[gi] != level_q) && ((deb_q + 1'b1) == c_deb_lim);
    assign rise     = deb_done &&  act[gi];
    assign fall     = deb_done && !act[gi];

    always_ff @(posedge clk27 or negedge reset_n) begin
      if (!reset_n) begin
        deb_q     <= '0;
        hold_q    <= '0;
        st_q      <= ST_IDLE;
        frozen_q  <= 1'b0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;

        // Any cycle agreeing with the accepted level restarts the count, so
        // a one-cycle glitch cannot accumulate toward a transition.
        if (act[gi] == level_q) begin
          deb_q <= '0;
        end else if (tick) begin
          if (deb_done) begin
            deb_q     <= '0;
            level_q   <= act[gi];
            press_q   <= act[gi];
            release_q <= !act[gi];
          end else begin
            deb_q <= deb_q + 1'b1;
          end
        end

        if (LONG_TICKS == 0) begin
          st_q     <= ST_IDLE;
          hold_q   <= '0;
          frozen_q <= 1'b0;
        end else begin
          case (st_q)
            ST_IDLE: begin
              hold_q   <= '0;
              frozen_q <= 1'b0;
              if (rise) st_q <= ST_HELD;
            end
            ST_HELD: begin
              // A release always wins over a coincident limit hit.
              if (fall) begin
                st_q     <= ST_IDLE;
                hold_q   <= '0;
                frozen_q <= 1'b0;
              end else if (tick && !frozen_q) begin
                if ((hold_q + 1'b1) == c_long_lim) begin
                  long_q <= 1'b1;
                  hold_q <= '0;
                  // Without repeat the counter freezes until release.
                  if (REPEAT_TICKS > 0) st_q <= ST_REPEAT;
                  else                  frozen_q <= 1'b1;
                end else begin
                  hold_q <= hold_q + 1'b1;
                end
              end
            end
            ST_REPEAT: begin
              if (fall) begin
                st_q     <= ST_IDLE;
                hold_q   <= '0;
                frozen_q <= 1'b0;
              end else if (tick) begin
                if ((hold_q + 1'b1) == c_rep_lim) begin
                  long_q <= 1'b1;
                  hold_q <= '0;
                end else begin
                  hold_q <= hold_q + 1'b1;
                end
              end
            end
            default: begin
              st_q     <= ST_IDLE;
              hold_q   <= '0;
              frozen_q <= 1'b0;
            end
          endcase
        end
      end
    end

    assign level_o[gi]   = level_q;
    assign press_o[gi]   = press_q;
    assign release_o[gi] = release_q;
    assign long_o[gi]    = long_q;
  end

  // All pulse sources are registered, so this OR is glitch-free and lands in
  // the same cycle as the pulses themselves.
  assign any_event_o = |(press_o | release_o | long_o);

endmodule
`default_nettype wire
